muldiv_unit: RTL and testbench

Iterative multiply/divide unit in the EX stage of the 5-stage MIPS pipeline, directly downstream of the register file. It consumes the two register read operands (rs, rt) and holds the architectural HI/LO registers. It executes MULT/MULTU/DIV/DIVU over 33 cycles, performs MTHI/MTLO in one cycle, and exports a stall request so the hazard logic freezes IF/ID/EX while a result is pending.

---
 rtl/muldiv_pkg.sv | 19 +
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 33 +++
 rtl/muldiv_unit.sv | 136 +++++++++++++
 tb/tb_muldiv_unit.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op codes, FSM state codes and width defaults
// for the iterative HI/LO multiply/divide unit.
package muldiv_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int CNT_W_DEF = 5;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CALC = 2'd1;
  localparam logic [1:0] S_FIN  = 2'd2;

endpackage

// File: rtl/muldiv_if.sv
// muldiv_if: EX-stage bundle to the mul/div unit.
// master drives Start/Op/A/B/Rd_HiLo; slave returns Busy/Stall/HI/LO.
interface muldiv_if
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);
  logic             Start;
  logic [2:0]       Op;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Rd_HiLo;
  logic             Busy;
  logic             Stall;
  logic [WIDTH-1:0] HI;
  logic [WIDTH-1:0] LO;

  modport master (
    output Start, Op, A, B, Rd_HiLo,
    input  Busy, Stall, HI, LO
  );

  modport slave (
    input  Start, Op, A, B, Rd_HiLo,
    output Busy, Stall, HI, LO
  );

endinterface

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration (shift-add or restoring
// subtract). in: is_div, acc, lo, m; out: acc_nx, lo_nx.
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] acc,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] m,
  output logic [WIDTH-1:0] acc_nx,
  output logic [WIDTH-1:0] lo_nx
);

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   shl;
  logic [WIDTH-1:0] dif;
  logic             ge;

  always_comb begin
    sum = {1'b0, acc} + (lo[0] ? {1'b0, m} : '0);
    shl = {acc, lo[WIDTH-1]};
    ge  = shl >= {1'b0, m};
    // true difference is below m when ge, so W bits suffice
    dif = shl[WIDTH-1:0] - m;
    acc_nx = sum[WIDTH:1];
    lo_nx  = {sum[0], lo[WIDTH-1:1]};
    if (is_div) begin
      acc_nx = ge ? dif : shl[WIDTH-1:0];
      lo_nx  = {lo[WIDTH-2:0], ge};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: 33-cycle MULT/MULTU/DIV/DIVU, 1-cycle MTHI/MTLO, HI/LO.
// ports: Clk, Clr (sync reset), bus (muldiv_if.slave).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input logic     Clk,
  input logic     Clr,
  muldiv_if.slave bus
);

  logic [1:0]         state;
  logic [CNT_W-1:0]   cnt;
  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   lo_w;
  logic [WIDTH-1:0]   m;
  logic [WIDTH-1:0]   a_org;
  logic [WIDTH-1:0]   hi_r;
  logic [WIDTH-1:0]   lo_r;
  logic               is_div;
  logic               neg_res;
  logic               neg_rem;
  logic               div_zero;
  logic [WIDTH-1:0]   acc_nx;
  logic [WIDTH-1:0]   lo_nx;
  logic               busy;
  logic               sgn;
  logic               a_neg;
  logic               b_neg;
  logic [WIDTH-1:0]   abs_a;
  logic [WIDTH-1:0]   abs_b;
  logic               go_md;
  logic               go_hi;
  logic               go_lo;
  logic [2*WIDTH-1:0] prod;
  logic [2*WIDTH-1:0] prod_fx;
  logic [WIDTH-1:0]   q_fx;
  logic [WIDTH-1:0]   r_fx;

  // ops 0 and 2 are the signed variants
  assign sgn   = ~bus.Op[0];
  assign a_neg = sgn & bus.A[WIDTH-1];
  assign b_neg = sgn & bus.B[WIDTH-1];
  assign abs_a = a_neg ? -bus.A : bus.A;
  assign abs_b = b_neg ? -bus.B : bus.B;

  assign go_md = bus.Start & ~bus.Op[2];
  assign go_hi = bus.Start & (bus.Op == OP_MTHI);
  assign go_lo = bus.Start & (bus.Op == OP_MTLO);

  assign prod    = {acc, lo_w};
  assign prod_fx = neg_res ? -prod : prod;
  assign q_fx    = neg_res ? -lo_w : lo_w;
  assign r_fx    = neg_rem ? -acc : acc;

  assign busy      = (state != S_IDLE);
  assign bus.Busy  = busy;
  assign bus.Stall = busy & (bus.Start | bus.Rd_HiLo);
  assign bus.HI    = hi_r;
  assign bus.LO    = lo_r;

  muldiv_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .is_div (is_div),
    .acc    (acc),
    .lo     (lo_w),
    .m      (m),
    .acc_nx (acc_nx),
    .lo_nx  (lo_nx)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state    <= S_IDLE;
      cnt      <= '0;
      acc      <= '0;
      lo_w     <= '0;
      m        <= '0;
      a_org    <= '0;
      hi_r     <= '0;
      lo_r     <= '0;
      is_div   <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          unique case (1'b1)
            go_md: begin
              state    <= S_CALC;
              cnt      <= '0;
              acc      <= '0;
              is_div   <= bus.Op[1];
              // lo_w holds the multiplier or the dividend
              lo_w     <= bus.Op[1] ? abs_a : abs_b;
              m        <= bus.Op[1] ? abs_b : abs_a;
              neg_res  <= a_neg ^ b_neg;
              neg_rem  <= a_neg;
              div_zero <= bus.Op[1] & (bus.B == '0);
              a_org    <= bus.A;
            end
            go_hi:   hi_r <= bus.A;
            go_lo:   lo_r <= bus.A;
            default: ;
          endcase
        end
        S_CALC: begin
          acc  <= acc_nx;
          lo_w <= lo_nx;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= S_FIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
          if (is_div) begin
            hi_r <= div_zero ? a_org : r_fx;
            lo_r <= div_zero ? '1 : q_fx;
          end else begin
            hi_r <= prod_fx[2*WIDTH-1:WIDTH];
            lo_r <= prod_fx[WIDTH-1:0];
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed + random ops against a 64-bit arithmetic
// model of HI/LO, Busy and Stall, compared every cycle.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;

  logic Clk = 1'b0;
  logic Clr;
  always #5 Clk = ~Clk;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(
    .WIDTH (W),
    .CNT_W (5)
  ) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (bus)
  );

  int vecs = 0;
  int errs = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // reference: plain 64-bit arithmetic
  function automatic void ref_op(input logic [2:0] op,
                                 input logic [31:0] a,
                                 input logic [31:0] b,
                                 output logic [31:0] hi,
                                 output logic [31:0] lo);
    logic signed [63:0] sa, sb, sr;
    logic [63:0] up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    hi = '0;
    lo = '0;
    case (op)
      3'd0: begin
        sr = sa * sb;
        hi = sr[63:32];
        lo = sr[31:0];
      end
      3'd1: begin
        up = {32'b0, a} * {32'b0, b};
        hi = up[63:32];
        lo = up[31:0];
      end
      3'd2: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          sr = sa / sb;
          lo = sr[31:0];
          sr = sa % sb;
          hi = sr[31:0];
        end
      end
      3'd3: begin
        if (b == 0) begin
          hi = a;
          lo = '1;
        end else begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endfunction

  int          m_left = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;
  logic [31:0] p_hi, p_lo;
  bit          cmp_en = 1'b0;

  always @(posedge Clk) begin
    if (Clr) begin
      m_left = 0;
      m_hi = '0;
      m_lo = '0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (bus.Start) begin
      if (bus.Op <= 3'd3) begin
        ref_op(bus.Op, bus.A, bus.B, p_hi, p_lo);
        m_left = W + 1;
      end else if (bus.Op == OP_MTHI) begin
        m_hi = bus.A;
      end else if (bus.Op == OP_MTLO) begin
        m_lo = bus.A;
      end
    end
  end

  always @(negedge Clk) begin
    #2;
    if (cmp_en) begin
      chk("busy", 32'(bus.Busy), 32'(m_left > 0));
      chk("stall", 32'(bus.Stall),
          32'((m_left > 0) && (bus.Start || bus.Rd_HiLo)));
      chk("hi", bus.HI, m_hi);
      chk("lo", bus.LO, m_lo);
    end
  end

  task automatic do_op(input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int mode,
                       output int busy_n);
    bus.Start = 1'b1;
    bus.Op = op;
    bus.A = a;
    bus.B = b;
    bus.Rd_HiLo = 1'b0;
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.A = $urandom;
    bus.B = $urandom;
    busy_n = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.Busy) break;
      busy_n++;
      case (mode)
        1: begin
          bus.Start = ($urandom_range(0, 3) == 0);
          bus.Op = 3'($urandom);
          bus.A = $urandom;
          bus.B = $urandom;
          bus.Rd_HiLo = 1'($urandom_range(0, 1));
        end
        2: begin
          bus.Start = (i < 16);
          bus.Op = OP_DIVU;
          bus.Rd_HiLo = (i >= 16);
          #1 chk("stall_hold", 32'(bus.Stall), 32'd1);
        end
        default: ;
      endcase
      @(negedge Clk);
    end
    chk("busy_timeout", 32'(bus.Busy), 32'd0);
    bus.Start = 1'b0;
    bus.Rd_HiLo = 1'b0;
  endtask

  function automatic logic [31:0] rnd_val();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    logic [2:0] op;
    Clr = 1'b1;
    bus.Start = 1'b0;
    bus.Op = '0;
    bus.A = '0;
    bus.B = '0;
    bus.Rd_HiLo = 1'b0;
    repeat (2) @(negedge Clk);
    cmp_en = 1'b1;
    chk("rst_busy", 32'(bus.Busy), 32'd0);
    chk("rst_hi", bus.HI, 32'h0);
    chk("rst_lo", bus.LO, 32'h0);
    Clr = 1'b0;

    do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, n);
    chk("multu_busy_n", 32'(n), 32'd33);
    chk("multu_hi", bus.HI, 32'hFFFF_FFFE);
    chk("multu_lo", bus.LO, 32'h0000_0001);
    chk("model_multu_hi", m_hi, 32'hFFFF_FFFE);

    do_op(OP_MULT, 32'hFFFF_FFFD, 32'd5, 0, n);
    chk("mult_hi", bus.HI, 32'hFFFF_FFFF);
    chk("mult_lo", bus.LO, 32'hFFFF_FFF1);
    chk("model_mult_lo", m_lo, 32'hFFFF_FFF1);

    do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, n);
    chk("div_lo", bus.LO, 32'hFFFF_FFFD);
    chk("div_hi", bus.HI, 32'hFFFF_FFFF);
    chk("model_div_hi", m_hi, 32'hFFFF_FFFF);

    do_op(OP_DIVU, 32'd7, 32'd0, 0, n);
    chk("dz_busy_n", 32'(n), 32'd33);
    chk("dz_lo", bus.LO, 32'hFFFF_FFFF);
    chk("dz_hi", bus.HI, 32'd7);

    do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, n);
    chk("ovf_lo", bus.LO, 32'h8000_0000);
    chk("ovf_hi", bus.HI, 32'h0);
    chk("model_ovf_lo", m_lo, 32'h8000_0000);

    do_op(OP_MULT, 32'd1234, 32'd5678, 2, n);
    chk("hold_busy_n", 32'(n), 32'd33);
    chk("hold_lo", bus.LO, 32'h006A_E9BC);
    chk("hold_hi", bus.HI, 32'h0);

    do_op(OP_MTHI, 32'h1234_5678, 32'h0, 0, n);
    chk("mthi_busy_n", 32'(n), 32'd0);
    chk("mthi_hi", bus.HI, 32'h1234_5678);
    do_op(OP_MTLO, 32'hCAFE_F00D, 32'h0, 0, n);
    chk("mtlo_lo", bus.LO, 32'hCAFE_F00D);

    bus.Start = 1'b1;
    bus.Op = OP_DIV;
    bus.A = 32'd100;
    bus.B = 32'd7;
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (9) @(negedge Clk);
    Clr = 1'b1;
    @(negedge Clk);
    Clr = 1'b0;
    #1;
    chk("clr_busy", 32'(bus.Busy), 32'd0);
    chk("clr_stall", 32'(bus.Stall), 32'd0);
    chk("clr_hi", bus.HI, 32'h0);
    chk("clr_lo", bus.LO, 32'h0);
    @(negedge Clk);
    do_op(OP_MULTU, 32'd6, 32'd7, 0, n);
    chk("post_clr_lo", bus.LO, 32'd42);
    chk("post_clr_hi", bus.HI, 32'd0);

    do_op(OP_MULT, 32'd3, 32'd4, 0, n);
    do_op(OP_MULT, 32'hFFFF_FFFE, 32'd7, 0, n);
    chk("b2b_busy_n", 32'(n), 32'd33);
    chk("b2b_lo", bus.LO, 32'hFFFF_FFF2);
    chk("b2b_hi", bus.HI, 32'hFFFF_FFFF);

    for (int k = 0; k < 1000; k++) begin
      if ($urandom_range(0, 9) < 8) op = 3'($urandom_range(0, 3));
      else op = 3'($urandom_range(4, 7));
      do_op(op, rnd_val(), rnd_val(), $urandom_range(0, 1), n);
    end

    @(negedge Clk);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
